pila_param: RTL and testbench

- Parametrised hardware stack (LIFO) for the processor's subroutine-return and data-stack paths.
- Synchronous, with clock enable.
- Provides full/empty/level status, sticky overflow/underflow error flags, and a single-cycle replace-top operation (simultaneous push and pop).
- Sits between the control unit (which drives push/pop) and the PC/data-return mux (which consumes salidaDatos).

---
 rtl/pila_param.sv | 90 +++++++++
 tb/tb_pila_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pila_param.sv
// rtl/pila_param.sv - parametrised LIFO stack with replace-top and sticky error flags
module pila_param #(
    parameter int DATA = 8,
    parameter int ADDR = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            activa,
    input  logic            push,
    input  logic            pop,
    input  logic [DATA-1:0] entradaDatos,
    input  logic            limpiaError,
    output logic [DATA-1:0] salidaDatos,
    output logic            vacia,
    output logic            llena,
    output logic [ADDR:0]   nivel,
    output logic            desbordamiento,
    output logic            subdesbordamiento
);

    localparam logic [ADDR:0] DEPTH = (ADDR+1)'(1) << ADDR;

    logic [DATA-1:0] mem [0:(1<<ADDR)-1];
    logic [ADDR:0]   sp;
    logic [ADDR:0]   sp_m1;
    logic [ADDR-1:0] top_idx;
    logic [ADDR-1:0] waddr;
    logic            is_empty;
    logic            is_full;
    logic            do_push;
    logic            do_pop;
    logic            do_repl;
    logic            ev_ovf;
    logic            ev_udf;

    assign sp_m1    = sp - (ADDR+1)'(1);
    assign top_idx  = sp_m1[ADDR-1:0];
    assign is_empty = (sp == '0);
    assign is_full  = (sp == DEPTH);

    // push+pop on an empty stack degrades to a plain push
    assign do_push = activa & push & ((~pop & ~is_full) | (pop & is_empty));
    assign do_pop  = activa & pop & ~push & ~is_empty;
    assign do_repl = activa & push & pop & ~is_empty;
    assign ev_ovf  = activa & push & ~pop & is_full;
    assign ev_udf  = activa & pop & ~push & is_empty;

    assign waddr = do_repl ? top_idx : sp[ADDR-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + (ADDR+1)'(1);
        end else if (do_pop) begin
            sp <= sp_m1;
        end
    end

    // Storage is deliberately unreset; the empty-gate on salidaDatos hides stale contents
    always_ff @(posedge clk) begin
        if (do_push || do_repl) begin
            mem[waddr] <= entradaDatos;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            desbordamiento    <= 1'b0;
            subdesbordamiento <= 1'b0;
        end else begin
            if (ev_ovf) begin
                desbordamiento <= 1'b1;
            end else if (limpiaError) begin
                desbordamiento <= 1'b0;
            end
            if (ev_udf) begin
                subdesbordamiento <= 1'b1;
            end else if (limpiaError) begin
                subdesbordamiento <= 1'b0;
            end
        end
    end

    assign salidaDatos = is_empty ? '0 : mem[top_idx];
    assign vacia       = is_empty;
    assign llena       = is_full;
    assign nivel       = sp;

endmodule

// File: tb/tb_pila_param.sv
// tb/tb_pila_param.sv - directed bench for pila_param with a queue-based reference model
module tb_pila_param;

    localparam int DATA  = 8;
    localparam int ADDR  = 2;
    localparam int DEPTH = 1 << ADDR;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            activa = 1'b0;
    logic            push = 1'b0;
    logic            pop = 1'b0;
    logic [DATA-1:0] entradaDatos = '0;
    logic            limpiaError = 1'b0;
    logic [DATA-1:0] salidaDatos;
    logic            vacia;
    logic            llena;
    logic [ADDR:0]   nivel;
    logic            desbordamiento;
    logic            subdesbordamiento;

    int checks = 0;
    int fails  = 0;
    bit started = 1'b0;

    pila_param #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk               (clk),
        .reset             (reset),
        .activa            (activa),
        .push              (push),
        .pop               (pop),
        .entradaDatos      (entradaDatos),
        .limpiaError       (limpiaError),
        .salidaDatos       (salidaDatos),
        .vacia             (vacia),
        .llena             (llena),
        .nivel             (nivel),
        .desbordamiento    (desbordamiento),
        .subdesbordamiento (subdesbordamiento)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a plain queue, flags as bits
    logic [DATA-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;
    bit ev_o, ev_u;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            ev_o = 1'b0;
            ev_u = 1'b0;
            if (activa) begin
                if (push && pop) begin
                    if (q.size() == 0) q.push_back(entradaDatos);
                    else q[q.size()-1] = entradaDatos;
                end else if (push) begin
                    if (q.size() == DEPTH) ev_o = 1'b1;
                    else q.push_back(entradaDatos);
                end else if (pop) begin
                    if (q.size() == 0) ev_u = 1'b1;
                    else void'(q.pop_back());
                end
            end
            if (ev_o) m_ovf = 1'b1;
            else if (limpiaError) m_ovf = 1'b0;
            if (ev_u) m_udf = 1'b1;
            else if (limpiaError) m_udf = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model salidaDatos", 32'(salidaDatos), (q.size() == 0) ? 32'h0 : 32'(q[q.size()-1]));
            check("model nivel", 32'(nivel), 32'(q.size()));
            check("model vacia", 32'(vacia), 32'(q.size() == 0));
            check("model llena", 32'(llena), 32'(q.size() == DEPTH));
            check("model desbordamiento", 32'(desbordamiento), 32'(m_ovf));
            check("model subdesbordamiento", 32'(subdesbordamiento), 32'(m_udf));
        end
    end

    task automatic op(input bit a, input bit p, input bit o, input logic [7:0] d, input bit l);
        @(negedge clk);
        activa = a;
        push = p;
        pop = o;
        entradaDatos = d;
        limpiaError = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " vacia"}, 32'(vacia), 32'd1);
        check({tag, " llena"}, 32'(llena), 32'd0);
        check({tag, " nivel"}, 32'(nivel), 32'd0);
        check({tag, " salidaDatos"}, 32'(salidaDatos), 32'h00);
        check({tag, " desbordamiento"}, 32'(desbordamiento), 32'd0);
        check({tag, " subdesbordamiento"}, 32'(subdesbordamiento), 32'd0);
    endtask

    logic [7:0] fill_vals [4];
    logic [7:0] drain_vals [4];

    initial begin
        fill_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain_vals = '{8'h33, 8'h22, 8'h11, 8'h00};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        started = 1'b1;
        #1;
        check_reset_outputs("reset");

        for (int i = 0; i < 4; i++) begin
            op(1, 1, 0, fill_vals[i], 0);
            check("fill top", 32'(salidaDatos), 32'(fill_vals[i]));
        end
        check("fill nivel", 32'(nivel), 32'd4);
        check("fill llena", 32'(llena), 32'd1);
        op(1, 1, 0, 8'h55, 0);
        check("overflow flag", 32'(desbordamiento), 32'd1);
        check("overflow nivel", 32'(nivel), 32'd4);
        check("overflow top", 32'(salidaDatos), 32'h44);

        for (int i = 0; i < 4; i++) begin
            op(1, 0, 1, 8'h00, 0);
            check("drain top", 32'(salidaDatos), 32'(drain_vals[i]));
        end
        check("drain vacia", 32'(vacia), 32'd1);
        op(1, 0, 1, 8'h00, 0);
        check("underflow flag", 32'(subdesbordamiento), 32'd1);
        check("underflow nivel", 32'(nivel), 32'd0);

        op(1, 0, 0, 8'h00, 1);
        check("clear ovf", 32'(desbordamiento), 32'd0);
        op(1, 1, 0, 8'hA0, 0);
        op(1, 1, 1, 8'hB0, 0);
        check("replace nivel", 32'(nivel), 32'd1);
        check("replace top", 32'(salidaDatos), 32'hB0);
        op(1, 0, 1, 8'h00, 0);
        op(1, 1, 1, 8'hC0, 0);
        check("pushpop empty nivel", 32'(nivel), 32'd1);
        check("pushpop empty top", 32'(salidaDatos), 32'hC0);
        op(0, 1, 0, 8'hEE, 0);
        check("gated nivel", 32'(nivel), 32'd1);
        check("gated top", 32'(salidaDatos), 32'hC0);

        // replace when full must not flag overflow
        op(1, 1, 0, 8'h01, 0);
        op(1, 1, 0, 8'h02, 0);
        op(1, 1, 0, 8'h03, 0);
        op(1, 1, 1, 8'h99, 0);
        check("full replace top", 32'(salidaDatos), 32'h99);
        check("full replace no ovf", 32'(desbordamiento), 32'd0);
        for (int i = 0; i < 4; i++) op(1, 0, 1, 8'h00, 0);
        check("empty again", 32'(vacia), 32'd1);

        op(1, 0, 1, 8'h00, 0);
        op(1, 0, 1, 8'h00, 1);
        check("set beats clear", 32'(subdesbordamiento), 32'd1);
        op(1, 0, 0, 8'h00, 1);
        check("clear udf", 32'(subdesbordamiento), 32'd0);

        op(1, 1, 0, 8'h77, 0);
        op(1, 1, 0, 8'h88, 0);
        op(0, 0, 0, 8'h00, 0);
        check("pre-reset nivel", 32'(nivel), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        reset = 1'b0;
        op(1, 0, 1, 8'h00, 0);
        check("post-reset udf", 32'(subdesbordamiento), 32'd1);
        check("post-reset top", 32'(salidaDatos), 32'h00);
        op(0, 0, 0, 8'h00, 0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
